// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the memory port arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int DEF_MAX_WAIT = 3;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with synchronous clear
module arb_sat_counter #(
    parameter int MAX   = 3,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    // clear has priority so a grant or completion always restarts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_VAL)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        gnt_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);

    arb_state_t state, state_next;

    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              if_cand, dm_cand;
    logic              grant_if, grant_dm;
    logic              busy, tmo_hit, finish;

    // a requester whose done is showing this cycle sits out one arbitration
    assign if_cand  = if_req && !if_done;
    assign dm_cand  = dm_req && !dm_done;
    assign grant_if = (state == IDLE) && if_cand
                      && (!dm_cand || (wait_cnt == WAIT_W'(MAX_WAIT)));
    assign grant_dm = (state == IDLE) && dm_cand && !grant_if;

    assign busy    = (state != IDLE);
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign finish  = busy && (mem_ready || tmo_hit);

    arb_sat_counter #(
        .MAX   (MAX_WAIT),
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk (clk),
        .rst (reset),
        .clr (grant_if),
        .inc (grant_dm && if_req),
        .cnt (wait_cnt)
    );

    arb_sat_counter #(
        .MAX   (TIMEOUT - 1),
        .WIDTH (TMO_W)
    ) u_tmo_cnt (
        .clk (clk),
        .rst (reset),
        .clr (!busy || finish),
        .inc (busy),
        .cnt (tmo_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_next = BUSY_IF;
                end else if (grant_dm) begin
                    state_next = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_ready wins over a simultaneous timeout, so err is simply !mem_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_done   <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
            err       <= 1'b0;
            gnt_sel   <= SEL_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_done  <= 1'b0;
            if_rdata <= '0;
            dm_done  <= 1'b0;
            dm_rdata <= '0;
            err      <= 1'b0;
            if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                gnt_sel   <= SEL_IF;
            end else if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                gnt_sel   <= SEL_DM;
            end else if (finish) begin
                mem_req <= 1'b0;
                err     <= !mem_ready;
                if (state == BUSY_IF) begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_ready ? mem_rdata : '0;
                end else begin
                    dm_done  <= 1'b1;
                    dm_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        err;
    logic        gnt_sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    exp_t if_q[$];
    exp_t dm_q[$];
    logic grants[$];
    int   rise_cycles[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          mem_lat = 1;
    logic [31:0] mem_data = '0;
    logic        inject_ready = 1'b0;
    logic        starve = 1'b0;
    logic        mem_req_q = 1'b0;
    int          busy_len = 0;
    int          last_busy_len = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .err       (err),
        .gnt_sel   (gnt_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // requests stay up while the bench still expects completions
    task automatic drive_reqs();
        logic if_busy;
        if_busy = mem_req && (gnt_sel == SEL_IF);
        if_req  = (if_q.size() != 0) && !(starve && dm_done && !if_busy);
        dm_req  = (dm_q.size() != 0);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        checks++;
        if ((if_done && dm_done) || (err && !if_done && !dm_done)) begin
            errors++;
            $display("FAIL done_exclusive cycle %0d: if_done=%b dm_done=%b err=%b, required one done at most and err only with done",
                     cycle, if_done, dm_done, err);
        end
        if (if_done) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++;
                $display("FAIL if_done_unexpected cycle %0d: if_done=1, required 0", cycle);
            end else begin
                e = if_q.pop_front();
                if (if_rdata !== e.rdata || err !== e.err) begin
                    errors++;
                    $display("FAIL if_done_result cycle %0d: rdata=%h err=%b, required rdata=%h err=%b",
                             cycle, if_rdata, err, e.rdata, e.err);
                end
            end
        end
        if (dm_done) begin
            checks++;
            if (dm_q.size() == 0) begin
                errors++;
                $display("FAIL dm_done_unexpected cycle %0d: dm_done=1, required 0", cycle);
            end else begin
                e = dm_q.pop_front();
                if (dm_rdata !== e.rdata || err !== e.err) begin
                    errors++;
                    $display("FAIL dm_done_result cycle %0d: rdata=%h err=%b, required rdata=%h err=%b",
                             cycle, dm_rdata, err, e.rdata, e.err);
                end
            end
        end
        if (mem_req && !mem_req_q) begin
            grants.push_back(gnt_sel);
            rise_cycles.push_back(cycle);
            busy_len = 1;
        end else if (mem_req) begin
            busy_len++;
        end else if (mem_req_q) begin
            last_busy_len = busy_len;
        end
        mem_req_q = mem_req;
        if (inject_ready && !mem_req) begin
            mem_ready    = 1'b1;
            mem_rdata    = mem_data;
            inject_ready = 1'b0;
        end else if (mem_req && mem_lat != 0 && busy_len == mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem_data;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
        end
        drive_reqs();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || mem_req) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_drain: pending if=%0d dm=%0d mem_req=%b after %0d cycles, required all completed",
                     name, if_q.size(), dm_q.size(), mem_req, n);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if_done, if_rdata, dm_done, dm_rdata, err, gnt_sel, mem_req, mem_we, mem_addr, mem_wdata} !== 134'd0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b gnt_sel=%b mem_addr=%h err=%b, required all zero",
                     mem_req, gnt_sel, mem_addr, err);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: mem_req=%b, required 0", mem_req);
        end
    endtask

    task automatic test_if_read();
        mem_lat  = 2;
        mem_data = 32'hDEAD_BEEF;
        if_addr  = 32'h0000_0040;
        if_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        drive_reqs();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || gnt_sel !== SEL_IF || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL if_read_grant: mem_req=%b addr=%h sel=%b we=%b wdata=%h, required 1 00000040 0 0 00000000",
                     mem_req, mem_addr, gnt_sel, mem_we, mem_wdata);
        end
        drain("if_read");
        checks++;
        if (last_busy_len != 2) begin
            errors++;
            $display("FAIL if_read_busy_len: %0d cycles, required 2", last_busy_len);
        end
    endtask

    task automatic test_dm_write();
        mem_lat  = 1;
        mem_data = 32'hCAFE_F00D;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0100;
        dm_wdata = 32'h1234_5678;
        dm_q.push_back('{rdata: 32'h0, err: 1'b0});
        drive_reqs();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234_5678 || gnt_sel !== SEL_DM) begin
            errors++;
            $display("FAIL dm_write_grant: req=%b we=%b addr=%h wdata=%h sel=%b, required 1 1 00000100 12345678 1",
                     mem_req, mem_we, mem_addr, mem_wdata, gnt_sel);
        end
        drain("dm_write");
        dm_we    = 1'b0;
        dm_addr  = 32'h0000_0104;
        mem_data = 32'h0BAD_C0DE;
        dm_q.push_back('{rdata: 32'h0BAD_C0DE, err: 1'b0});
        drive_reqs();
        drain("dm_read");
    endtask

    task automatic test_timeout();
        mem_lat = 0;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0200;
        dm_q.push_back('{rdata: 32'h0, err: 1'b1});
        drive_reqs();
        drain("timeout");
        checks++;
        if (last_busy_len != 16) begin
            errors++;
            $display("FAIL timeout_busy_len: %0d cycles, required 16", last_busy_len);
        end
        mem_data     = 32'h7777_7777;
        inject_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_ignored: mem_req=%b, required 0", mem_req);
        end
    endtask

    task automatic test_coincidence();
        mem_lat  = 16;
        mem_data = 32'h5A5A_A5A5;
        dm_we    = 1'b0;
        dm_addr  = 32'h0000_0300;
        dm_q.push_back('{rdata: 32'h5A5A_A5A5, err: 1'b0});
        drive_reqs();
        drain("coincidence");
        checks++;
        if (last_busy_len != 16) begin
            errors++;
            $display("FAIL coincidence_busy_len: %0d cycles, required 16", last_busy_len);
        end
    endtask

    task automatic test_back_to_back();
        mem_lat  = 1;
        mem_data = 32'h3C3C_0001;
        dm_addr  = 32'h0000_0400;
        rise_cycles.delete();
        for (int i = 0; i < 3; i++) dm_q.push_back('{rdata: 32'h3C3C_0001, err: 1'b0});
        drive_reqs();
        drain("back_to_back");
        checks++;
        if (rise_cycles.size() != 3) begin
            errors++;
            $display("FAIL b2b_grant_count: %0d grants, required 3", rise_cycles.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rise_cycles[i] - rise_cycles[i-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_period %0d: %0d cycles, required 3", i, rise_cycles[i] - rise_cycles[i-1]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_g [10];
        exp_g = '{SEL_DM, SEL_DM, SEL_DM, SEL_IF, SEL_DM, SEL_DM, SEL_DM, SEL_IF, SEL_DM, SEL_DM};
        mem_lat  = 1;
        mem_data = 32'h1111_2222;
        if_addr  = 32'h0000_0080;
        dm_addr  = 32'h0000_0500;
        grants.delete();
        for (int i = 0; i < 2; i++) if_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
        for (int i = 0; i < 8; i++) dm_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
        starve = 1'b1;
        drive_reqs();
        drain("starvation");
        starve = 1'b0;
        checks++;
        if (grants.size() != 10) begin
            errors++;
            $display("FAIL starve_grant_count: %0d grants, required 10", grants.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (grants[i] !== exp_g[i]) begin
                    errors++;
                    $display("FAIL starve_grant %0d: sel=%b, required %b", i, grants[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_lat  = 0;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0600;
        dm_wdata = 32'hA5A5_5A5A;
        dm_q.push_back('{rdata: 32'h0, err: 1'b1});
        drive_reqs();
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({if_done, if_rdata, dm_done, dm_rdata, err, gnt_sel, mem_req, mem_we, mem_addr, mem_wdata} !== 134'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: mem_req=%b we=%b sel=%b addr=%h, required all zero",
                     mem_req, mem_we, gnt_sel, mem_addr);
        end
        dm_q.delete();
        dm_we = 1'b0;
        drive_reqs();
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: mem_req=%b, required 0", mem_req);
        end
        mem_lat  = 1;
        mem_data = 32'h0000_ABCD;
        if_addr  = 32'h0000_0044;
        if_q.push_back('{rdata: 32'h0000_ABCD, err: 1'b0});
        drive_reqs();
        tick();
        checks++;
        if (mem_req !== 1'b1 || gnt_sel !== SEL_IF || mem_addr !== 32'h44) begin
            errors++;
            $display("FAIL reset_mid_recover: req=%b sel=%b addr=%h, required 1 0 00000044",
                     mem_req, gnt_sel, mem_addr);
        end
        drain("reset_mid_recover");
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_timeout();
        test_coincidence();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single memory port between instruction fetch (IF) and data access (DM).
- Arbitrates between the two, registers the winner's request, and holds it on the port until the memory acknowledges or times out.
- Returns a one-cycle done pulse with read data to the winner.
- Drives the select line for the address/write-data 2-to-1 muxes in front of memory.

Parameters:
- MAX_WAIT, 3: consecutive arbitration losses IF may suffer before IF is forced to win.
- TIMEOUT, 16: cycles in a busy state without mem_ready before the access is aborted with an error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF access request; held until if_done.
- if_addr  in  32  IF address (always a read).
- if_done  out  1  one-cycle pulse: IF access finished.
- if_rdata  out  32  IF read data; valid only while if_done=1.
- dm_req  in  1  DM access request; held until dm_done.
- dm_we  in  1  DM write enable.
- dm_addr  in  32  DM address.
- dm_wdata  in  32  DM write data.
- dm_done  out  1  one-cycle pulse: DM access finished.
- dm_rdata  out  32  DM read data; valid only while dm_done=1 and the access was a read.
- err  out  1  qualifies a done pulse: the access timed out.
- gnt_sel  out  1  mux select: 0 = IF, 1 = DM; the registered owner of the port.
- mem_req  out  1  request to memory, held until mem_ready or timeout.
- mem_we  out  1  registered write enable (0 for IF).
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data (0 for IF).
- mem_ready  in  1  one-cycle acknowledge from memory.
- mem_rdata  in  32  memory read data, valid with mem_ready.

Behaviour:
- Reset (asynchronous):
  - State = IDLE; wait_cnt = 0; tmo_cnt = 0.
  - All outputs are 0, including gnt_sel, mem_*, done pulses, rdata and err.
  - Reset during BUSY drops the in-flight access. No done pulse is issued; requesters re-request.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - The arbitration decision is made combinationally from req inputs on a clock edge.
  - Both requesting: DM wins unless wait_cnt == MAX_WAIT, in which case IF wins.
  - Single requester wins.
  - On a grant, next cycle: state = BUSY_x, mem_req = 1, and mem_addr/mem_we/mem_wdata/gnt_sel are registered from the winner.
- Grant latency: req high in IDLE at edge N, so mem_req = 1 after edge N.
- wait_cnt:
  - Increments on an IDLE grant to DM while if_req = 1; saturates at MAX_WAIT.
  - Cleared on any grant to IF.
  - Width is clog2(MAX_WAIT+1).
- BUSY_x:
  - mem_* and gnt_sel are held stable; tmo_cnt increments each cycle.
  - mem_ready = 1: after the edge, x_done = 1 for one cycle with x_rdata = captured mem_rdata (0 for DM writes), err = 0, mem_req = 0, state = IDLE, tmo_cnt = 0.
  - tmo_cnt reaches TIMEOUT-1 with no mem_ready: after the edge, x_done = 1, err = 1, x_rdata = 0, mem_req = 0, state = IDLE.
  - mem_ready and the timeout on the same cycle: mem_ready wins, err = 0.
- Back-to-back:
  - During a done cycle the arbiter is in IDLE. The requester whose done is asserted is masked from arbitration for that one cycle; the other requester may be granted.
  - The earliest re-grant to the same requester is the cycle after its done. This gives a minimum 3-cycle period per requester with zero-wait memory.
- mem_ready while IDLE is ignored: no done pulse, no state change.
- Request changes while BUSY are ignored (fields are already registered). A requester must not drop req before done; if it does, the access still completes and done still pulses.
- if_done and dm_done are never high in the same cycle. err is 0 whenever no done is high.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM);
  - select constants SEL_IF = 1'b0 and SEL_DM = 1'b1;
  - the MAX_WAIT and TIMEOUT defaults.
- One natural sub-module, arb_sat_counter: a parameterised saturating counter with clear/increment, instantiated for wait_cnt and tmo_cnt.
- The external address/wdata muxes reuse the existing Mux2_1 driven by gnt_sel.

Test Plan:
- Reset mid-access: assert reset while in BUSY_DM -> all outputs 0 immediately (asynchronous); no dm_done afterwards; IDLE on release.
- Single IF read: if_req=1 with if_addr=0x0000_0040; memory gives mem_ready on the 2nd busy cycle with rdata=0xDEAD_BEEF -> mem_req for 2 cycles, mem_addr=0x40, gnt_sel=0, then if_done=1 for one cycle with if_rdata=0xDEADBEEF and err=0.
- Contention: both request continuously, zero-wait memory, MAX_WAIT=3 -> grant order DM, DM, DM, IF, DM, ...; wait_cnt returns to 0 after the IF grant.
- DM write: dm_we=1, dm_addr=0x100, dm_wdata=0x1234_5678 -> mem_we=1, mem_wdata=0x12345678, dm_done with dm_rdata=0.
- Timeout: TIMEOUT=16, mem_ready never asserted -> mem_req high exactly 16 cycles, then dm_done=1 and err=1; a late mem_ready pulse in IDLE is ignored.
- Coincidence: mem_ready on the same cycle tmo_cnt=15 -> done with err=0 and valid rdata.
